// File: rtl/regfile_sequencer.sv
// Four-state (IDLE/READ/EXEC/WRITE) instruction sequencer driving an external register file.
// Optional build macro DATAPATH_R0_ZERO_EN makes register 0 read as zero and unwritable.
module regfile_sequencer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  InstValid,
  output logic                  InstReady,
  input  logic [2:0]            OpCode,
  input  logic [2:0]            DstAddr,
  input  logic [2:0]            SrcAAddr,
  input  logic [2:0]            SrcBAddr,
  output logic [2:0]            AAddress,
  output logic [2:0]            BAddress,
  input  logic [DATA_WIDTH-1:0] AData,
  input  logic [DATA_WIDTH-1:0] BData,
  output logic [2:0]            DAddress,
  output logic [DATA_WIDTH-1:0] DData,
  output logic                  ReadOrWrite,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero,
  output logic                  Carry,
  output logic                  Done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV, OP_SHL
  } op_t;

  state_t r_state;
  state_t w_next;

  op_t                   r_op;
  logic [2:0]            r_dst;
  logic [2:0]            r_src_a;
  logic [2:0]            r_src_b;
  logic [DATA_WIDTH-1:0] r_opa;
  logic [DATA_WIDTH-1:0] r_opb;
  logic [2:0]            r_daddr;
  logic [DATA_WIDTH-1:0] r_ddata;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_carry;
  logic                  r_wr;

  logic [DATA_WIDTH-1:0] w_opa_in;
  logic [DATA_WIDTH-1:0] w_opb_in;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic                  w_alu_carry;
  logic                  w_accept;

  assign w_accept = (r_state == IDLE) && InstValid;

`ifdef DATAPATH_R0_ZERO_EN
  // Register 0 is hard-wired to zero: mask its reads and suppress its writes.
  assign w_opa_in = (r_src_a == 3'd0) ? '0 : AData;
  assign w_opb_in = (r_src_b == 3'd0) ? '0 : BData;
  assign w_wr_en  = (r_dst != 3'd0);
`else
  assign w_opa_in = AData;
  assign w_opb_in = BData;
  assign w_wr_en  = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (InstValid) w_next = READ;
      READ:  w_next = EXEC;
      EXEC:  w_next = WRITE;
      WRITE: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (r_op)
      OP_ADD: {w_alu_carry, w_alu_res} = {1'b0, r_opa} + {1'b0, r_opb};
      OP_SUB: begin
        w_alu_res   = r_opa - r_opb;
        w_alu_carry = (r_opa >= r_opb);
      end
      OP_AND: w_alu_res = r_opa & r_opb;
      OP_OR:  w_alu_res = r_opa | r_opb;
      OP_XOR: w_alu_res = r_opa ^ r_opb;
      OP_NOT: w_alu_res = ~r_opa;
      OP_MOV: w_alu_res = r_opa;
      OP_SHL: begin
        w_alu_res   = {r_opa[DATA_WIDTH-2:0], 1'b0};
        w_alu_carry = r_opa[DATA_WIDTH-1];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_ADD;
      r_dst    <= '0;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_daddr  <= '0;
      r_ddata  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= op_t'(OpCode);
        r_dst   <= DstAddr;
        r_src_a <= SrcAAddr;
        r_src_b <= SrcBAddr;
      end
      if (r_state == READ) begin
        r_opa <= w_opa_in;
        r_opb <= w_opb_in;
      end
      // Write-side outputs load only here, so they stay frozen through WRITE.
      if (r_state == EXEC) begin
        r_result <= w_alu_res;
        r_ddata  <= w_alu_res;
        r_zero   <= (w_alu_res == '0);
        r_carry  <= w_alu_carry;
        r_daddr  <= r_dst;
      end
      r_wr <= (r_state == EXEC) && w_wr_en;
    end
  end

  assign InstReady   = (r_state == IDLE);
  assign Done        = (r_state == WRITE);
  assign AAddress    = r_src_a;
  assign BAddress    = r_src_b;
  assign DAddress    = r_daddr;
  assign DData       = r_ddata;
  assign Result      = r_result;
  assign Zero        = r_zero;
  assign Carry       = r_carry;
  assign ReadOrWrite = r_wr;

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 16, as the operand/result width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  sole clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- InstValid  in  1  instruction present
- InstReady  out  1  sequencer can accept an instruction
- OpCode  in  3  operation select
- DstAddr  in  3  destination register
- SrcAAddr  in  3  operand A register
- SrcBAddr  in  3  operand B register
- AAddress  out  3  register-file A read address
- BAddress  out  3  register-file B read address
- AData  in  DATA_WIDTH  register-file A read data
- BData  in  DATA_WIDTH  register-file B read data
- DAddress  out  3  register-file write address
- DData  out  DATA_WIDTH  register-file write data
- ReadOrWrite  out  1  register-file write enable, active high
- Result  out  DATA_WIDTH  last computed result
- Zero  out  1  last result was zero
- Carry  out  1  carry/no-borrow/shift-out of the last operation
- Done  out  1  one-cycle pulse on instruction completion

Function
REQ-003 The FSM SHALL have four states: IDLE, READ, EXEC and WRITE.
REQ-004 Transitions SHALL be IDLE->READ on InstValid&&InstReady, READ->EXEC, EXEC->WRITE and WRITE->IDLE, each unconditional after one cycle.
REQ-005 InstReady SHALL be 1 only in IDLE; InstValid outside IDLE SHALL be ignored and no input is latched.
REQ-006 On accept, OpCode, DstAddr, SrcAAddr and SrcBAddr SHALL be latched, and AAddress/BAddress SHALL be driven from the latched values from READ onward.
REQ-007 At the READ->EXEC edge, AData and BData SHALL be captured into operand registers OpA and OpB.
REQ-008 At the EXEC->WRITE edge, Result, DData, Zero and Carry SHALL be registered and DAddress SHALL be loaded with the latched DstAddr.
REQ-009 Operations (Carry=0 unless stated) SHALL be:
- 0 ADD: A+B, Carry = carry-out
- 1 SUB: A-B modulo 2^DATA_WIDTH, Carry = 1 iff A>=B unsigned
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT A
- 6 MOV A
- 7 SHL A by 1, Carry = A[MSB]
REQ-010 Zero SHALL be 1 iff the registered Result is all zeros.
REQ-011 ReadOrWrite SHALL be a registered decode, 1 exactly during the WRITE cycle and 0 otherwise.
REQ-012 DAddress and DData SHALL NOT change while ReadOrWrite is 1, and SHALL hold their values until the next EXEC->WRITE edge.
REQ-013 Done SHALL be 1 exactly during the WRITE cycle.
REQ-014 Latency SHALL be fixed: accept edge to WRITE cycle is 3 cycles, and InstReady is 1 again on the 4th cycle after accept.
REQ-015 Maximum throughput SHALL be 1 instruction per 4 cycles.
REQ-016 With SrcA==SrcB, both operands SHALL be the same register value.
REQ-017 With DstAddr equal to a source, the read SHALL complete before the write; no hazard is handled or needed.

Reset
REQ-018 Asserting rst_n low SHALL immediately, without a clock, force state IDLE and drive ReadOrWrite=0, Done=0, InstReady=1, all address outputs 0, DData=0, Result=0, Zero=0, Carry=0.
REQ-019 Reset asserted mid-instruction SHALL abort the instruction with no write issued; an in-flight write cycle SHALL be cut off at reset assertion.
REQ-020 After rst_n deasserts, the first rising edge SHALL accept an instruction if InstValid=1.

Configuration
REQ-021 Macro DATAPATH_R0_ZERO_EN, when defined, SHALL make register 0 read as zero and unwritable.
REQ-022 With DATAPATH_R0_ZERO_EN defined, an operand whose source address is 0 SHALL be captured as 0 regardless of AData/BData.
REQ-023 With DATAPATH_R0_ZERO_EN defined and DstAddr==0, WRITE SHALL still occur with Done=1 and Result/flags updated, but ReadOrWrite SHALL stay 0.
REQ-024 Without DATAPATH_R0_ZERO_EN, register 0 SHALL behave as an ordinary register.

Verification
REQ-025 The bench SHALL cover ADD, r1=0x7FFF, r2=0x0001, dst r3 -> in the WRITE cycle (3 cycles after accept): DAddress=3, DData=0x8000, ReadOrWrite=1, Done=1, Zero=0, Carry=0.
REQ-026 The bench SHALL cover SUB, r1=0x0001, r2=0x0002 -> DData=0xFFFF, Carry=0; then SUB, r2=r1=0x0005 -> DData=0x0000, Zero=1, Carry=1.
REQ-027 The bench SHALL cover SHL, A=0x8001 -> DData=0x0002, Carry=1.
REQ-028 The bench SHALL cover InstValid held at 1 continuously with 3 queued instructions -> accepts exactly 4 cycles apart, and ReadOrWrite high exactly one cycle per instruction.
REQ-029 The bench SHALL cover rst_n pulsed low during EXEC -> ReadOrWrite never asserts, outputs are 0 asynchronously, and InstReady=1.
REQ-030 The bench SHALL cover, with DATAPATH_R0_ZERO_EN, MOV from r0 (AData=0x1234) to r0 -> Result=0x0000, Zero=1, Done=1, ReadOrWrite stays 0.
